image_mode_scheduler: RTL and testbench

- Sequences the `image_mode` control bus that drives the per-pixel processing stages (grayscaler, colour converters, bypass) in the HDMI video path.
- Accepts mode-change commands from the control side through a valid/ready handshake.
- Applies each change only inside vertical blanking, so a mode never changes mid-frame.
- Holds each applied mode for a programmable number of frames, and can run an automatic demo cycle through the modes.

---
 rtl/image_mode_pkg.sv | 21 ++
 rtl/vs_edge_detect.sv | 20 ++
 rtl/image_mode_scheduler.sv | 173 +++++++++++++++++
 tb/tb_image_mode_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_mode_pkg.sv
// Shared types and constants for the image_mode scheduler and the pixel stages it drives.
package image_mode_pkg;

    localparam int MODE_W_DEF = 8;
    localparam int HOLD_W     = 8;

    localparam logic [7:0] MODE_BYPASS = 8'd0;
    localparam logic [7:0] MODE_GRAY   = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLD
    } sched_state_e;

    // A hold of zero frames would never let the mode settle, so it is promoted to one.
    function automatic logic [HOLD_W-1:0] norm_hold(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_W'(1) : h;
    endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// Registers vertical sync once and flags its rising and falling edges.
module vs_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic vs_i,
    output logic rise_o,
    output logic fall_o
);

    logic vs_q;

    always_ff @(posedge clock) begin
        if (reset) vs_q <= 1'b0;
        else       vs_q <= vs_i;
    end

    assign rise_o = vs_i & ~vs_q;
    assign fall_o = ~vs_i & vs_q;

endmodule

// File: rtl/image_mode_scheduler.sv
// Applies image_mode changes only in vertical blanking and holds them for N frames.
// Optional watchdog on missing vsync: define IMAGE_MODE_SCHED_WDOG_EN (adds wdog_o).
module image_mode_scheduler
    import image_mode_pkg::*;
#(
    parameter int MODE_W      = MODE_W_DEF,
    parameter int MODE_COUNT  = 4,
    parameter int AUTO_FRAMES = 60,
    parameter int FRAME_CNT_W = 16,
    parameter int WDOG_CYCLES = 2_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   vs_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [MODE_W-1:0]      cmd_mode_i,
    input  logic [HOLD_W-1:0]      cmd_hold_i,
    input  logic                   auto_en_i,
    output logic [MODE_W-1:0]      image_mode_o,
    output logic                   mode_update_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   busy_o
`ifdef IMAGE_MODE_SCHED_WDOG_EN
   ,output logic                   wdog_o
`endif
);

    localparam int AUTO_W = (MODE_COUNT > 1) ? $clog2(MODE_COUNT) : 1;

    logic vs_rise, vs_fall;

    sched_state_e            state_q, state_d;
    logic                    ready_q, ready_d;
    logic [MODE_W-1:0]       mode_q, mode_d;
    logic                    upd_q, upd_d;
    logic [MODE_W-1:0]       pend_mode_q, pend_mode_d;
    logic [HOLD_W-1:0]       pend_hold_q, pend_hold_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [AUTO_W-1:0]       auto_idx_q, auto_idx_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    vs_edge_detect u_vs_edge (
        .clock  (clock),
        .reset  (reset),
        .vs_i   (vs_i),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

`ifdef IMAGE_MODE_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_q, wdog_d;
    logic              wdog_trip;

    // Counter saturates at the limit so a stuck vsync trips only once.
    assign wdog_trip = !vs_rise && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        wdog_d     = wdog_q;
        if (vs_rise) begin
            wdog_cnt_d = '0;
            wdog_d     = 1'b0;
        end else begin
            if (wdog_cnt_q != WDOG_W'(WDOG_CYCLES)) wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            if (wdog_trip) wdog_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign wdog_o = wdog_q;
`else
    logic wdog_trip;
    assign wdog_trip = 1'b0;
`endif

    // Timeout and stage constants are configuration for other builds and blocks.
    logic unused_cfg;
    assign unused_cfg = ^{MODE_GRAY, 32'(WDOG_CYCLES)};

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        upd_d       = 1'b0;
        pend_mode_d = pend_mode_q;
        pend_hold_d = pend_hold_q;
        hold_cnt_d  = hold_cnt_q;
        auto_idx_d  = auto_idx_q;
        frame_cnt_d = vs_rise ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    pend_mode_d = cmd_mode_i;
                    pend_hold_d = norm_hold(cmd_hold_i);
                    state_d     = ST_ARMED;
                end else if (auto_en_i) begin
                    pend_mode_d = MODE_W'(auto_idx_q);
                    pend_hold_d = norm_hold(HOLD_W'(AUTO_FRAMES));
                    auto_idx_d  = (auto_idx_q == AUTO_W'(MODE_COUNT - 1)) ? '0
                                                                          : auto_idx_q + AUTO_W'(1);
                    state_d     = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vs_fall) begin
                    mode_d     = pend_mode_q;
                    upd_d      = (pend_mode_q != mode_q);
                    hold_cnt_d = pend_hold_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0)
                    state_d = ST_IDLE;
                else if (vs_rise)
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (wdog_trip) begin
            mode_d  = MODE_W'(MODE_BYPASS);
            upd_d   = (mode_q != MODE_W'(MODE_BYPASS));
            state_d = ST_IDLE;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            mode_q      <= MODE_W'(MODE_BYPASS);
            upd_q       <= 1'b0;
            pend_mode_q <= '0;
            pend_hold_q <= '0;
            hold_cnt_q  <= '0;
            auto_idx_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            mode_q      <= mode_d;
            upd_q       <= upd_d;
            pend_mode_q <= pend_mode_d;
            pend_hold_q <= pend_hold_d;
            hold_cnt_q  <= hold_cnt_d;
            auto_idx_q  <= auto_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cmd_ready_o   = ready_q;
    assign image_mode_o  = mode_q;
    assign mode_update_o = upd_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_image_mode_scheduler.sv
// Directed bench for image_mode_scheduler; frames are 4 cycles of vsync high, 8 low.
module tb_image_mode_scheduler;

    localparam int MODE_W      = 8;
    localparam int MODE_COUNT  = 4;
    localparam int AUTO_FRAMES = 2;
    localparam int FRAME_CNT_W = 16;
    localparam int WDOG_CYCLES = 200;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   vs_i;
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic [MODE_W-1:0]      cmd_mode_i;
    logic [7:0]             cmd_hold_i;
    logic                   auto_en_i;
    logic [MODE_W-1:0]      image_mode_o;
    logic                   mode_update_o;
    logic [FRAME_CNT_W-1:0] frame_cnt_o;
    logic                   busy_o;
`ifdef IMAGE_MODE_SCHED_WDOG_EN
    logic                   wdog_o;
`endif

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int u0;

    image_mode_scheduler #(
        .MODE_W      (MODE_W),
        .MODE_COUNT  (MODE_COUNT),
        .AUTO_FRAMES (AUTO_FRAMES),
        .FRAME_CNT_W (FRAME_CNT_W),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .vs_i          (vs_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_mode_i    (cmd_mode_i),
        .cmd_hold_i    (cmd_hold_i),
        .auto_en_i     (auto_en_i),
        .image_mode_o  (image_mode_o),
        .mode_update_o (mode_update_o),
        .frame_cnt_o   (frame_cnt_o),
        .busy_o        (busy_o)
`ifdef IMAGE_MODE_SCHED_WDOG_EN
       ,.wdog_o        (wdog_o)
`endif
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (mode_update_o === 1'b1) upd_cnt++;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic frame();
        vs_i = 1'b1;
        repeat (4) step();
        vs_i = 1'b0;
        repeat (8) step();
    endtask

    task automatic issue(input logic [7:0] m, input logic [7:0] h);
        cmd_valid_i = 1'b1;
        cmd_mode_i  = m;
        cmd_hold_i  = h;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vs_i = 1'b0; cmd_valid_i = 1'b0; auto_en_i = 1'b0;
        cmd_mode_i = '0; cmd_hold_i = '0;
        step(); step();
        checks++; if (image_mode_o !== 8'd0) begin errors++; $display("FAIL rst_mode got %0d want 0", image_mode_o); end
        checks++; if (mode_update_o !== 1'b0) begin errors++; $display("FAIL rst_upd got %b want 0", mode_update_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_frame got %0d want 0", frame_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", cmd_ready_o); end
        reset = 1'b0;
        u0 = upd_cnt;
        repeat (3) frame();
        checks++; if (frame_cnt_o !== 16'd3) begin errors++; $display("FAIL idle_frames got %0d want 3", frame_cnt_o); end
        checks++; if (image_mode_o !== 8'd0) begin errors++; $display("FAIL idle_mode got %0d want 0", image_mode_o); end
        checks++; if (upd_cnt - u0 != 0) begin errors++; $display("FAIL idle_pulses got %0d want 0", upd_cnt - u0); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", cmd_ready_o); end
    endtask

    task automatic test_command();
        u0 = upd_cnt;
        issue(8'd3, 8'd2);
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL cmd_ready_drop got %b want 0", cmd_ready_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL cmd_busy got %b want 1", busy_o); end
        vs_i = 1'b1;
        repeat (4) step();
        vs_i = 1'b0;
        checks++; if (image_mode_o !== 8'd0) begin errors++; $display("FAIL cmd_early got %0d want 0", image_mode_o); end
        step();
        checks++; if (image_mode_o !== 8'd3 || mode_update_o !== 1'b1) begin errors++; $display("FAIL cmd_apply got mode %0d upd %b want mode 3 upd 1", image_mode_o, mode_update_o); end
        step();
        checks++; if (mode_update_o !== 1'b0) begin errors++; $display("FAIL cmd_pulse_len got %b want 0", mode_update_o); end
        repeat (6) step();
        frame();
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL cmd_hold1 got %b want 0", cmd_ready_o); end
        frame();
        checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL cmd_hold_end got ready %b busy %b want 1 0", cmd_ready_o, busy_o); end
        checks++; if (upd_cnt - u0 != 1) begin errors++; $display("FAIL cmd_pulses got %0d want 1", upd_cnt - u0); end
        checks++; if (frame_cnt_o !== 16'd6) begin errors++; $display("FAIL cmd_frames got %0d want 6", frame_cnt_o); end
    endtask

    task automatic test_busy_cmd();
        u0 = upd_cnt;
        cmd_valid_i = 1'b1; cmd_mode_i = 8'd5; cmd_hold_i = 8'd1;
        step();
        cmd_mode_i = 8'd7;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", cmd_ready_o); end
        frame();
        checks++; if (image_mode_o !== 8'd5) begin errors++; $display("FAIL busy_nohs got %0d want 5", image_mode_o); end
        vs_i = 1'b1;
        step(); step();
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL busy_ready_back got %b want 1", cmd_ready_o); end
        step();
        checks++; if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL busy_accept got ready %b busy %b want 0 1", cmd_ready_o, busy_o); end
        cmd_valid_i = 1'b0;
        step();
        vs_i = 1'b0;
        repeat (8) step();
        checks++; if (image_mode_o !== 8'd7) begin errors++; $display("FAIL busy_second got %0d want 7", image_mode_o); end
        frame();
        checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL busy_end got ready %b busy %b want 1 0", cmd_ready_o, busy_o); end
        checks++; if (upd_cnt - u0 != 2) begin errors++; $display("FAIL busy_pulses got %0d want 2", upd_cnt - u0); end
    endtask

    task automatic test_auto();
        int exp_mode[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        u0 = upd_cnt;
        auto_en_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            frame();
            checks++; if (image_mode_o !== 8'(exp_mode[i])) begin errors++; $display("FAIL auto_f%0d got %0d want %0d", i + 1, image_mode_o, exp_mode[i]); end
        end
        checks++; if (upd_cnt - u0 != 5) begin errors++; $display("FAIL auto_pulses got %0d want 5", upd_cnt - u0); end
        frame();
        vs_i = 1'b1;
        step();
        cmd_valid_i = 1'b1; cmd_mode_i = 8'd9; cmd_hold_i = 8'd1;
        step(); step();
        cmd_valid_i = 1'b0;
        step();
        vs_i = 1'b0;
        repeat (8) step();
        checks++; if (image_mode_o !== 8'd9) begin errors++; $display("FAIL auto_prio got %0d want 9", image_mode_o); end
        frame();
        checks++; if (image_mode_o !== 8'd1) begin errors++; $display("FAIL auto_idx_kept got %0d want 1", image_mode_o); end
        auto_en_i = 1'b0;
        frame();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL auto_off_hold got %b want 1", busy_o); end
        frame();
        checks++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || image_mode_o !== 8'd1) begin errors++; $display("FAIL auto_off_end got busy %b ready %b mode %0d want 0 1 1", busy_o, cmd_ready_o, image_mode_o); end
        checks++; if (frame_cnt_o !== 16'd23) begin errors++; $display("FAIL auto_frames got %0d want 23", frame_cnt_o); end
    endtask

    task automatic test_hold0_same();
        u0 = upd_cnt;
        issue(8'd1, 8'd0);
        frame();
        checks++; if (image_mode_o !== 8'd1 || busy_o !== 1'b1) begin errors++; $display("FAIL same_apply got mode %0d busy %b want 1 1", image_mode_o, busy_o); end
        checks++; if (upd_cnt - u0 != 0) begin errors++; $display("FAIL same_pulse got %0d want 0", upd_cnt - u0); end
        frame();
        checks++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL hold0_end got busy %b ready %b want 0 1", busy_o, cmd_ready_o); end
        issue(8'd4, 8'd0);
        frame();
        checks++; if (image_mode_o !== 8'd4 || busy_o !== 1'b1) begin errors++; $display("FAIL hold0_apply got mode %0d busy %b want 4 1", image_mode_o, busy_o); end
        checks++; if (upd_cnt - u0 != 1) begin errors++; $display("FAIL hold0_pulse got %0d want 1", upd_cnt - u0); end
        frame();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hold0_end2 got %b want 0", busy_o); end
    endtask

    task automatic test_reset_armed();
        u0 = upd_cnt;
        issue(8'd6, 8'd1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rarm_busy got %b want 1", busy_o); end
        vs_i = 1'b1;
        step(); step();
        reset = 1'b1;
        vs_i = 1'b0;
        step(); step();
        checks++; if (image_mode_o !== 8'd0 || busy_o !== 1'b0 || frame_cnt_o !== 16'd0) begin errors++; $display("FAIL rarm_rst got mode %0d busy %b frames %0d want 0 0 0", image_mode_o, busy_o, frame_cnt_o); end
        reset = 1'b0;
        frame(); frame();
        checks++; if (image_mode_o !== 8'd0 || upd_cnt - u0 != 0) begin errors++; $display("FAIL rarm_after got mode %0d pulses %0d want 0 0", image_mode_o, upd_cnt - u0); end
        checks++; if (cmd_ready_o !== 1'b1 || frame_cnt_o !== 16'd2) begin errors++; $display("FAIL rarm_idle got ready %b frames %0d want 1 2", cmd_ready_o, frame_cnt_o); end
    endtask

`ifdef IMAGE_MODE_SCHED_WDOG_EN
    task automatic test_wdog();
        u0 = upd_cnt;
        issue(8'd3, 8'd1);
        frame();
        checks++; if (image_mode_o !== 8'd3 || busy_o !== 1'b1) begin errors++; $display("FAIL wdog_pre got mode %0d busy %b want 3 1", image_mode_o, busy_o); end
        repeat (WDOG_CYCLES + 10) step();
        checks++; if (image_mode_o !== 8'd0 || wdog_o !== 1'b1) begin errors++; $display("FAIL wdog_trip got mode %0d wdog %b want 0 1", image_mode_o, wdog_o); end
        checks++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL wdog_idle got busy %b ready %b want 0 1", busy_o, cmd_ready_o); end
        checks++; if (upd_cnt - u0 != 2) begin errors++; $display("FAIL wdog_pulses got %0d want 2", upd_cnt - u0); end
        frame();
        checks++; if (wdog_o !== 1'b0) begin errors++; $display("FAIL wdog_clear got %b want 0", wdog_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_command();
        test_busy_cmd();
        test_auto();
        test_hold0_same();
        test_reset_armed();
`ifdef IMAGE_MODE_SCHED_WDOG_EN
        test_wdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
